tree_node_upstream_merger: RTL and testbench
============================================

# tree_node_upstream_merger

Fan-in counterpart to the hierarchy's fan-out nodes: merges upstream message traffic from up to N_CHILD child instances into a single stream toward the parent node. Child selection is round-robin. Every accepted beat is registered and tagged with its source child index. A saturating counter reports the total number of beats delivered. One instance sits at each tree node that instantiates children.

## Interface
- N_CHILD, 5, number of child inputs (2..8)
- DATA_W, 16, payload width per beat
- SRC_W, $clog2(N_CHILD), width of the source tag
- CNT_W, 16, width of the forwarded-beat counter

- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- child_valid  input  N_CHILD  bit i: child i presents a beat
- child_ready  output  N_CHILD  bit i: beat from child i accepted this cycle
- child_data  input  N_CHILD*DATA_W  child i payload at bits [i*DATA_W +: DATA_W]
- up_valid  output  1  registered beat available to parent
- up_ready  input  1  parent accepts beat
- up_data  output  DATA_W  registered payload
- up_src  output  SRC_W  index of child that supplied up_data
- fwd_count  output  CNT_W  saturating count of completed upstream handshakes

## Operation
- Reset values:
  - up_valid=0, up_data=0, up_src=0, fwd_count=0.
  - Round-robin pointer ptr=0.
  - child_ready=0 in every cycle in which rst=1.
- Handshakes:
  - Child handshake on child i: child_valid[i] & child_ready[i].
  - Upstream handshake: up_valid & up_ready.
- Load enable: load_en = !up_valid | up_ready.
  - The output register can be refilled in the same cycle it drains.
- Grant:
  - When load_en=1 and any child_valid bit is set, grant the first index with valid asserted, searching ptr, ptr+1, … N_CHILD-1, 0, … ptr-1.
- child_ready:
  - One-hot at the grant index when load_en=1 and some valid is present; otherwise all zero.
  - Combinationally depends on child_valid and up_ready. Children must not make child_valid depend on child_ready.
- On a grant at index g:
  - up_data <= child g data; up_src <= g; up_valid <= 1.
  - ptr <= g+1, wrapping N_CHILD-1 -> 0.
- No grant and upstream handshake: up_valid <= 0. up_data and up_src hold their last values.
- No grant and no handshake: all state holds.
- Backpressure: while up_valid=1 and up_ready=0, up_valid, up_data and up_src are stable and child_ready=0.
- Counter:
  - fwd_count increments by 1 on each upstream handshake.
  - It saturates at 2^CNT_W-1 and never wraps.
  - It is cleared only by rst.
- ptr advances only on a grant, never on idle cycles.
- Reset asserted mid-transfer discards the held beat (up_valid=0 next cycle). No child handshake occurs in that cycle.
- A child_valid bit on an index >= N_CHILD does not exist. Child indices 0..N_CHILD-1 only.

## Timing
- Latency: child handshake in cycle t -> up_valid=1 with that beat in cycle t+1.
- Throughput: one beat per cycle sustained when up_ready is held at 1. No bubble between consecutive beats.
- Fairness: with all children continuously valid and up_ready=1, each child is granted exactly once in every N_CHILD consecutive grants.
- fwd_count reflects a handshake in cycle t from cycle t+1.
- Simultaneous upstream handshake and new grant in cycle t:
  - The output register takes the new beat at t+1.
  - fwd_count increments at t+1.

## Test plan
- Single source: reset, then child 3 valid with data 0x00A3 for one cycle, up_ready=1. Required: child_ready=5'b01000 that cycle; next cycle up_valid=1, up_data=0x00A3, up_src=3; then up_valid=0 and fwd_count=1.
- All five valid continuously with data 0x0010+i, up_ready=1, from reset:
  - Required grants 0,1,2,3,4,0,… on consecutive cycles, with up_src following one cycle later.
  - fwd_count=10 after 10 delivered beats.
- Backpressure: child 1 valid with 0x1111, up_ready=0 for 4 cycles, then 1. Required: up_valid=1, up_data=0x1111, up_src=1 stable for all 4 cycles; child_ready=0 throughout; exactly one handshake; fwd_count=1.
- Wrap and pointer: grant child 4 (ptr becomes 0), then children 0 and 4 valid together. Required: grant 0 first, then 4.
- Reset mid-operation: children valid, up_valid=1, up_ready=0, assert rst for 1 cycle. Required next cycle: up_valid=0, fwd_count=0, ptr=0; child_ready=0 during the reset cycle; next grant goes to the lowest valid index.
- Saturation (CNT_W=3): complete 10 upstream handshakes. Required: fwd_count reads 7 after the 7th handshake and stays at 7.

Source files
------------

// File: rtl/tree_node_upstream_merger_if.sv
// Child-to-parent merge bus: N_CHILD upstream inputs and one registered output stream.
// The master modport is the merger itself; the slave modport is the surrounding environment.
interface tree_node_upstream_merger_if #(
    parameter int N_CHILD = 5,
    parameter int DATA_W  = 16,
    parameter int SRC_W   = $clog2(N_CHILD)
);
    logic [N_CHILD-1:0]        child_valid;
    logic [N_CHILD-1:0]        child_ready;
    logic [N_CHILD*DATA_W-1:0] child_data;
    logic                      up_valid;
    logic                      up_ready;
    logic [DATA_W-1:0]         up_data;
    logic [SRC_W-1:0]          up_src;

    modport master (
        input  child_valid, child_data, up_ready,
        output child_ready, up_valid, up_data, up_src
    );

    modport slave (
        output child_valid, child_data, up_ready,
        input  child_ready, up_valid, up_data, up_src
    );
endinterface

// File: rtl/tree_node_upstream_merger.sv
// Round-robin fan-in of child beats into one registered, source-tagged upstream stream,
// with a saturating count of beats handed to the parent.
module tree_node_upstream_merger #(
    parameter int N_CHILD = 5,
    parameter int DATA_W  = 16,
    parameter int SRC_W   = $clog2(N_CHILD),
    parameter int CNT_W   = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    tree_node_upstream_merger_if.master bus,
    output logic [CNT_W-1:0]            o_fwd_count
);
    logic [SRC_W-1:0]   r_ptr;
    logic               r_up_valid;
    logic [DATA_W-1:0]  r_up_data;
    logic [SRC_W-1:0]   r_up_src;
    logic [CNT_W-1:0]   r_fwd_count;

    logic               w_load_en;
    logic               w_up_hs;
    logic               w_gnt_vld;
    logic [SRC_W-1:0]   w_gnt_idx;
    logic [N_CHILD-1:0] w_child_ready;

    assign w_load_en = !r_up_valid || bus.up_ready;
    assign w_up_hs   = r_up_valid && bus.up_ready;

    // Scan from the highest offset down so the nearest valid child after ptr wins.
    always_comb begin : grant_search
        int               idx;
        logic [SRC_W-1:0] idx_s;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        idx       = 0;
        idx_s     = '0;
        for (int k = N_CHILD - 1; k >= 0; k--) begin
            idx = int'(r_ptr) + k;
            if (idx >= N_CHILD) idx = idx - N_CHILD;
            idx_s = SRC_W'(idx);
            if (bus.child_valid[idx_s]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = idx_s;
            end
        end
    end

    always_comb begin
        w_child_ready = '0;
        if (!i_rst && w_load_en && w_gnt_vld) w_child_ready[w_gnt_idx] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr       <= '0;
            r_up_valid  <= 1'b0;
            r_up_data   <= '0;
            r_up_src    <= '0;
            r_fwd_count <= '0;
        end else begin
            if (w_load_en && w_gnt_vld) begin
                r_up_valid <= 1'b1;
                r_up_data  <= bus.child_data[int'(w_gnt_idx)*DATA_W +: DATA_W];
                r_up_src   <= w_gnt_idx;
                r_ptr      <= (w_gnt_idx == SRC_W'(N_CHILD - 1)) ? '0 : w_gnt_idx + 1'b1;
            end else if (w_up_hs) begin
                r_up_valid <= 1'b0;
            end
            if (w_up_hs && r_fwd_count != {CNT_W{1'b1}})
                r_fwd_count <= r_fwd_count + 1'b1;
        end
    end

    assign bus.child_ready = w_child_ready;
    assign bus.up_valid    = r_up_valid;
    assign bus.up_data     = r_up_data;
    assign bus.up_src      = r_up_src;
    assign o_fwd_count     = r_fwd_count;
endmodule

// File: tb/tb_tree_node_upstream_merger.sv
// Directed bench for the upstream merger: main instance at defaults, second instance with a 3-bit counter.
module tb_tree_node_upstream_merger;
    localparam int N  = 5;
    localparam int DW = 16;
    localparam int SW = $clog2(N);

    logic clk;
    logic rst;
    logic [15:0] fwd_count;
    logic [2:0]  sat_count;
    int checks   = 0;
    int failures = 0;

    tree_node_upstream_merger_if #(.N_CHILD(N), .DATA_W(DW)) m_if ();
    tree_node_upstream_merger_if #(.N_CHILD(N), .DATA_W(DW)) s_if ();

    tree_node_upstream_merger #(.N_CHILD(N), .DATA_W(DW), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .bus(m_if.master), .o_fwd_count(fwd_count)
    );
    tree_node_upstream_merger #(.N_CHILD(N), .DATA_W(DW), .CNT_W(3)) dut_sat (
        .i_clk(clk), .i_rst(rst), .bus(s_if.master), .o_fwd_count(sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] v);
        m_if.child_data[i*DW +: DW] = v;
    endtask

    task automatic do_reset();
        m_if.child_valid = '0;
        m_if.up_ready    = 1'b0;
        s_if.child_valid = '0;
        s_if.up_ready    = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_if.child_valid = 5'b11111;
        m_if.up_ready    = 1'b1;
        for (int i = 0; i < N; i++) set_data(i, 16'h0050 + 16'(i));
        #1;
        checks++;
        if (m_if.child_ready !== 5'b00000) begin
            failures++;
            $display("FAIL reset_child_ready actual=%b required=00000", m_if.child_ready);
        end
        tick();
        tick();
        checks++;
        if (m_if.up_valid !== 1'b0 || m_if.up_data !== 16'h0 || m_if.up_src !== 3'd0 || fwd_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_state actual=v%b d%h s%0d c%0d required=v0 d0000 s0 c0",
                     m_if.up_valid, m_if.up_data, m_if.up_src, fwd_count);
        end
        rst = 1'b0;
        m_if.child_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        set_data(3, 16'h00A3);
        m_if.child_valid = 5'b01000;
        m_if.up_ready    = 1'b1;
        #1;
        checks++;
        if (m_if.child_ready !== 5'b01000) begin
            failures++;
            $display("FAIL single_ready actual=%b required=01000", m_if.child_ready);
        end
        tick();
        m_if.child_valid = '0;
        checks++;
        if (m_if.up_valid !== 1'b1 || m_if.up_data !== 16'h00A3 || m_if.up_src !== 3'd3) begin
            failures++;
            $display("FAIL single_beat actual=v%b d%h s%0d required=v1 d00a3 s3",
                     m_if.up_valid, m_if.up_data, m_if.up_src);
        end
        tick();
        checks++;
        if (m_if.up_valid !== 1'b0 || fwd_count !== 16'd1) begin
            failures++;
            $display("FAIL single_drain actual=v%b c%0d required=v0 c1", m_if.up_valid, fwd_count);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < N; i++) set_data(i, 16'h0010 + 16'(i));
        m_if.child_valid = 5'b11111;
        m_if.up_ready    = 1'b1;
        for (int c = 0; c < 10; c++) begin
            logic [4:0] exp_rdy;
            exp_rdy = 5'b00001 << (c % N);
            #1;
            checks++;
            if (m_if.child_ready !== exp_rdy) begin
                failures++;
                $display("FAIL rr_grant[%0d] actual=%b required=%b", c, m_if.child_ready, exp_rdy);
            end
            tick();
            checks++;
            if (m_if.up_valid !== 1'b1 || m_if.up_src !== 3'(c % N) || m_if.up_data !== 16'h0010 + 16'(c % N)) begin
                failures++;
                $display("FAIL rr_beat[%0d] actual=v%b s%0d d%h required=v1 s%0d d%h", c,
                         m_if.up_valid, m_if.up_src, m_if.up_data, c % N, 16'h0010 + 16'(c % N));
            end
        end
        m_if.child_valid = '0;
        tick();
        checks++;
        if (fwd_count !== 16'd10 || m_if.up_valid !== 1'b0) begin
            failures++;
            $display("FAIL rr_count actual=c%0d v%b required=c10 v0", fwd_count, m_if.up_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_data(1, 16'h1111);
        m_if.child_valid = 5'b00010;
        m_if.up_ready    = 1'b0;
        #1;
        checks++;
        if (m_if.child_ready !== 5'b00010) begin
            failures++;
            $display("FAIL bp_first_grant actual=%b required=00010", m_if.child_ready);
        end
        tick();
        set_data(1, 16'h2222);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (m_if.child_ready !== 5'b00000) begin
                failures++;
                $display("FAIL bp_ready[%0d] actual=%b required=00000", i, m_if.child_ready);
            end
            checks++;
            if (m_if.up_valid !== 1'b1 || m_if.up_data !== 16'h1111 || m_if.up_src !== 3'd1 || fwd_count !== 16'd0) begin
                failures++;
                $display("FAIL bp_hold[%0d] actual=v%b d%h s%0d c%0d required=v1 d1111 s1 c0", i,
                         m_if.up_valid, m_if.up_data, m_if.up_src, fwd_count);
            end
            tick();
        end
        m_if.child_valid = '0;
        m_if.up_ready    = 1'b1;
        tick();
        checks++;
        if (m_if.up_valid !== 1'b0 || fwd_count !== 16'd1) begin
            failures++;
            $display("FAIL bp_release actual=v%b c%0d required=v0 c1", m_if.up_valid, fwd_count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        set_data(4, 16'h0444);
        set_data(0, 16'h0400);
        m_if.up_ready    = 1'b1;
        m_if.child_valid = 5'b10000;
        #1;
        checks++;
        if (m_if.child_ready !== 5'b10000) begin
            failures++;
            $display("FAIL wrap_g4 actual=%b required=10000", m_if.child_ready);
        end
        tick();
        m_if.child_valid = 5'b10001;
        #1;
        checks++;
        if (m_if.child_ready !== 5'b00001 || m_if.up_src !== 3'd4) begin
            failures++;
            $display("FAIL wrap_g0 actual=%b s%0d required=00001 s4", m_if.child_ready, m_if.up_src);
        end
        tick();
        #1;
        checks++;
        if (m_if.child_ready !== 5'b10000 || m_if.up_src !== 3'd0 || m_if.up_data !== 16'h0400) begin
            failures++;
            $display("FAIL wrap_g4b actual=%b s%0d d%h required=10000 s0 d0400",
                     m_if.child_ready, m_if.up_src, m_if.up_data);
        end
        tick();
        m_if.child_valid = '0;
        checks++;
        if (m_if.up_src !== 3'd4 || m_if.up_data !== 16'h0444) begin
            failures++;
            $display("FAIL wrap_last actual=s%0d d%h required=s4 d0444", m_if.up_src, m_if.up_data);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_data(1, 16'h0101);
        set_data(2, 16'h0202);
        m_if.child_valid = 5'b00110;
        m_if.up_ready    = 1'b0;
        tick();
        rst = 1'b1;
        m_if.up_ready = 1'b1;
        #1;
        checks++;
        if (m_if.child_ready !== 5'b00000) begin
            failures++;
            $display("FAIL rstmid_ready actual=%b required=00000", m_if.child_ready);
        end
        tick();
        rst = 1'b0;
        checks++;
        if (m_if.up_valid !== 1'b0 || fwd_count !== 16'd0) begin
            failures++;
            $display("FAIL rstmid_state actual=v%b c%0d required=v0 c0", m_if.up_valid, fwd_count);
        end
        #1;
        checks++;
        if (m_if.child_ready !== 5'b00010) begin
            failures++;
            $display("FAIL rstmid_ptr actual=%b required=00010", m_if.child_ready);
        end
        m_if.child_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        s_if.child_data  = '0;
        s_if.child_data[15:0] = 16'h0777;
        s_if.child_valid = 5'b00001;
        s_if.up_ready    = 1'b1;
        tick();
        for (int h = 1; h <= 10; h++) begin
            logic [2:0] exp_c;
            exp_c = (h >= 7) ? 3'd7 : 3'(h);
            tick();
            checks++;
            if (sat_count !== exp_c) begin
                failures++;
                $display("FAIL sat_count[%0d] actual=%0d required=%0d", h, sat_count, exp_c);
            end
        end
        s_if.child_valid = '0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        m_if.child_valid = '0;
        m_if.child_data  = '0;
        m_if.up_ready    = 1'b0;
        s_if.child_valid = '0;
        s_if.child_data  = '0;
        s_if.up_ready    = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
